// File: rtl/fpu_scheduler.sv
// FP dispatch scheduler: hazard/port/divider stall logic, a write-back reservation
// shift register and the FP/integer pending-register scoreboards.
module fpu_scheduler #(
    parameter int ADD_LAT  = 3,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 10,
    parameter int SQRT_LAT = 12,
    parameter int MISC_LAT = 1,
    parameter int DEPTH    = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       disp_valid,
    input  logic [2:0] disp_class,
    input  logic [4:0] disp_rd,
    input  logic       disp_fp_dst,
    input  logic [4:0] disp_rs1,
    input  logic [4:0] disp_rs2,
    input  logic [4:0] disp_rs3,
    input  logic [2:0] disp_rs_used,
    output logic       disp_ready,
    output logic       issue_valid,
    output logic [2:0] issue_class,
    output logic       div_busy,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic       wb_fp_dst,
    output logic [2:0] wb_class
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       fp_dst;
        logic [2:0] cls;
    } slot_t;

    slot_t [DEPTH-1:0] slot, slot_nxt;
    logic [31:0]       pend_fp, pend_int, pend_fp_nxt, pend_int_nxt;
    logic [CW-1:0]     div_cnt, lat;
    logic [2:0]        rs_busy;
    logic              is_div, waw, port_free, accept;

    always_comb begin
        case (disp_class)
            3'd0:    lat = CW'(ADD_LAT);
            3'd1:    lat = CW'(MUL_LAT);
            3'd2:    lat = CW'(DIV_LAT);
            3'd3:    lat = CW'(SQRT_LAT);
            default: lat = CW'(MISC_LAT);
        endcase
    end

    assign is_div = (disp_class == 3'd2) || (disp_class == 3'd3);

    // The op lands in slot[L-1] after the shift, so slot[L] must be empty now.
    // With L == DEPTH nothing can be ahead of it and the loop never matches.
    always_comb begin
        port_free = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            if (i == int'(lat) && slot[i].valid) port_free = 1'b0;
    end

    assign rs_busy     = {pend_fp[disp_rs3], pend_fp[disp_rs2], pend_fp[disp_rs1]} & disp_rs_used;
    assign waw         = disp_fp_dst ? pend_fp[disp_rd] : pend_int[disp_rd];
    assign disp_ready  = ~|rs_busy & ~waw & port_free & ~(is_div & div_busy);
    assign accept      = disp_valid & disp_ready;
    assign issue_valid = accept;
    assign issue_class = disp_class;

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) slot_nxt[i] = slot[i+1];
        slot_nxt[DEPTH-1] = '0;
        for (int i = 0; i < DEPTH; i++)
            if (accept && i == int'(lat) - 1)
                slot_nxt[i] = '{valid: 1'b1, rd: disp_rd, fp_dst: disp_fp_dst, cls: disp_class};
    end

    // Retire clears and accept sets never hit the same bit: the hazard check
    // stalls any op whose destination is still pending, including in its retire cycle.
    always_comb begin
        pend_fp_nxt  = pend_fp;
        pend_int_nxt = pend_int;
        if (slot[0].valid) begin
            if (slot[0].fp_dst) pend_fp_nxt[slot[0].rd]  = 1'b0;
            else                pend_int_nxt[slot[0].rd] = 1'b0;
        end
        if (accept) begin
            if (disp_fp_dst)          pend_fp_nxt[disp_rd]  = 1'b1;
            else if (disp_rd != 5'd0) pend_int_nxt[disp_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot     <= '0;
            pend_fp  <= '0;
            pend_int <= '0;
            div_cnt  <= '0;
        end else begin
            slot     <= slot_nxt;
            pend_fp  <= pend_fp_nxt;
            pend_int <= pend_int_nxt;
            if (accept && is_div)   div_cnt <= lat - CW'(1);
            else if (div_cnt != '0) div_cnt <= div_cnt - CW'(1);
        end
    end

    assign div_busy  = (div_cnt != '0);
    assign wb_valid  = slot[0].valid;
    assign wb_rd     = slot[0].rd;
    assign wb_fp_dst = slot[0].fp_dst;
    assign wb_class  = slot[0].cls;

endmodule

// File: tb/tb_fpu_scheduler.sv
// Bench for fpu_scheduler: directed scenarios plus random dispatch, all checked
// against a list of in-flight ops with absolute completion cycles.
module tb_fpu_scheduler;

    localparam int DEPTH = 12;   // sqrt latency equals DEPTH here

    logic       clk = 1'b0, rstn = 1'b0;
    logic       disp_valid = 1'b0, disp_fp_dst = 1'b0;
    logic [2:0] disp_class = '0, disp_rs_used = '0;
    logic [4:0] disp_rd = '0, disp_rs1 = '0, disp_rs2 = '0, disp_rs3 = '0;
    logic       disp_ready, issue_valid, div_busy, wb_valid, wb_fp_dst;
    logic [2:0] issue_class, wb_class;
    logic [4:0] wb_rd;

    always #5 clk = ~clk;

    fpu_scheduler #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .disp_valid(disp_valid), .disp_class(disp_class),
        .disp_rd(disp_rd), .disp_fp_dst(disp_fp_dst), .disp_rs1(disp_rs1),
        .disp_rs2(disp_rs2), .disp_rs3(disp_rs3), .disp_rs_used(disp_rs_used),
        .disp_ready(disp_ready), .issue_valid(issue_valid), .issue_class(issue_class),
        .div_busy(div_busy), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_fp_dst(wb_fp_dst), .wb_class(wb_class)
    );

    typedef struct {int rd; bit fp; int cls; int due;} op_t;
    op_t q[$];
    int  cyc = 0, checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(int c);
        case (c)
            0: return 3;
            1: return 2;
            2: return 10;
            3: return 12;
            default: return 1;
        endcase
    endfunction

    // A destination stays pending from the cycle after accept through its write-back cycle.
    function automatic bit m_pend(bit fp, int r);
        if (!fp && r == 0) return 0;
        foreach (q[i]) if (q[i].fp == fp && q[i].rd == r && q[i].due >= cyc) return 1;
        return 0;
    endfunction

    function automatic bit m_divbusy();
        foreach (q[i]) if ((q[i].cls == 2 || q[i].cls == 3) && q[i].due > cyc) return 1;
        return 0;
    endfunction

    function automatic bit m_port_taken(int due);
        foreach (q[i]) if (q[i].due == due) return 1;
        return 0;
    endfunction

    task automatic step(input bit v, input int c, input int rd, input bit fp,
                        input int r1, input int r2, input int r3, input int used);
        bit exp_ready, raw, dv, found;
        int L;
        op_t e, w;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        disp_valid = v; disp_class = c[2:0]; disp_rd = rd[4:0]; disp_fp_dst = fp;
        disp_rs1 = r1[4:0]; disp_rs2 = r2[4:0]; disp_rs3 = r3[4:0]; disp_rs_used = used[2:0];
        #1;
        L   = lat_of(c);
        raw = (used[0] && m_pend(1, r1)) || (used[1] && m_pend(1, r2)) || (used[2] && m_pend(1, r3));
        dv  = m_divbusy();
        exp_ready = !raw && !m_pend(fp, rd) && !m_port_taken(cyc + L) && !((c == 2 || c == 3) && dv);
        chk("disp_ready", disp_ready, exp_ready);
        chk("issue_valid", issue_valid, v && exp_ready);
        chk("issue_class", issue_class, c[2:0]);
        chk("div_busy", div_busy, dv);
        found = 0;
        foreach (q[i]) if (q[i].due == cyc) begin found = 1; w = q[i]; end
        chk("wb_valid", wb_valid, found);
        if (found) begin
            chk("wb_rd", wb_rd, w.rd);
            chk("wb_fp_dst", wb_fp_dst, w.fp);
            chk("wb_class", wb_class, w.cls);
        end
        if (v && exp_ready) begin
            e.rd = rd; e.fp = fp; e.cls = c; e.due = cyc + L;
            q.push_back(e);
        end
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].due <= cyc) q.delete(i);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Assert reset mid-cycle; everything registered must clear without waiting for an edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        disp_valid = 1'b0;
        q.delete();
        #1;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_class", wb_class, 0);
        chk("rst_div_busy", div_busy, 0);
        chk("rst_ready", disp_ready, 1);
        cyc++;
    endtask

    initial begin
        repeat (3) @(posedge clk);

        // reset discards in-flight fadd f1; f1 must not be pending afterwards
        step(1, 0, 1, 1, 0, 0, 0, 0);
        do_reset();
        idle(4);
        step(1, 1, 2, 1, 1, 0, 0, 3'b001);
        idle(4);

        // single ops: fadd f3, fmul f4, feq x5
        step(1, 0, 3, 1, 0, 0, 0, 0); idle(4);
        step(1, 1, 4, 1, 0, 0, 0, 0); idle(3);
        step(1, 4, 5, 0, 1, 2, 0, 3'b011); idle(2);

        // write-back collision: fmul f2 stalls one cycle behind fadd f1
        step(1, 0, 1, 1, 0, 0, 0, 0);
        repeat (2) step(1, 1, 2, 1, 0, 0, 0, 0);
        idle(5);

        // RAW on f1 through its retire cycle
        step(1, 0, 1, 1, 0, 0, 0, 0);
        repeat (4) step(1, 1, 6, 1, 1, 0, 0, 3'b001);
        idle(4);

        // WAW on f7 behind a divide, then back-to-back x0 writers
        step(1, 2, 7, 1, 0, 0, 0, 0);
        repeat (11) step(1, 0, 7, 1, 0, 0, 0, 0);
        idle(4);
        repeat (2) step(1, 4, 0, 0, 0, 0, 0, 0);
        idle(3);

        // divider occupancy: fsqrt f9 waits for fdiv f8 and enters as f8 writes back
        step(1, 2, 8, 1, 0, 0, 0, 0);
        repeat (10) step(1, 3, 9, 1, 0, 0, 0, 0);
        idle(14);

        // random traffic over a small register set so hazards are frequent
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(399) == 0) do_reset();
            else step($urandom_range(4) != 0, $urandom_range(7), $urandom_range(7),
                      $urandom_range(1), $urandom_range(7), $urandom_range(7),
                      $urandom_range(7), $urandom_range(7));
        end
        idle(DEPTH + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
